// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer between the UART byte streams and the Sobel core: validates and
// replays the W/H header, forwards pixels, counts in/out bytes, aborts on stalls.
module sobel_frame_ctrl #(
  parameter int DATA_BITS      = 8,
  parameter int MAX_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_BITS-1:0] rx_data_i,
  input  logic                 rx_valid_i,
  output logic [DATA_BITS-1:0] core_data_o,
  output logic                 core_valid_o,
  output logic                 core_ready_o,
  output logic                 core_rst_o,
  input  logic [DATA_BITS-1:0] core_out_data_i,
  input  logic                 core_out_valid_i,
  output logic [DATA_BITS-1:0] tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic                 frame_error_o
);
  localparam int HW = 2 * DATA_BITS;
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_CHECK, S_REPLAY, S_STREAM, S_DRAIN, S_DONE, S_DISCARD
  } state_t;

  state_t state_q, state_d;

  logic [3:0][DATA_BITS-1:0] hdr_q, hdr_d;
  logic [1:0]                hcnt_q, hcnt_d, rcnt_q, rcnt_d;
  logic [31:0]               total_q, total_d, pix_in_q, pix_in_d, pix_out_q, pix_out_d;
  logic [IW-1:0]             idle_q, idle_d;
  logic [DATA_BITS-1:0]      skid_q, skid_d, fwd_q, fwd_d, out_q, out_d;
  logic                      skid_vld_q, skid_vld_d, fwd_vld_q, fwd_vld_d;
  logic                      out_full_q, out_full_d, rst_q;

  logic [HW-1:0] hdr_w, hdr_h;
  logic hdr_ok, tx_hs, out_room, activity, timeout_hit, overflow, abort, take;

  assign hdr_w       = {hdr_q[1], hdr_q[0]};
  assign hdr_h       = {hdr_q[3], hdr_q[2]};
  assign hdr_ok      = (hdr_w != '0) && (hdr_w <= HW'(MAX_WIDTH)) && (hdr_h != '0);
  assign tx_hs       = out_full_q & tx_ready_i;
  assign out_room    = ~out_full_q | tx_ready_i;
  assign activity    = rx_valid_i | tx_hs;
  assign timeout_hit = ~activity && (idle_q == IW'(TIMEOUT_CYCLES - 1));
  // A core byte arriving with nowhere to go loses data, so the frame is abandoned.
  assign overflow    = (state_q == S_STREAM || state_q == S_DRAIN) &&
                       core_out_valid_i && !out_room;
  assign abort       = overflow || (timeout_hit &&
                       (state_q == S_HDR || state_q == S_STREAM || state_q == S_DRAIN));
  assign take        = (state_q == S_STREAM) && (skid_vld_q || rx_valid_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (rx_valid_i) state_d = S_HDR;
      S_HDR:     if (abort) state_d = S_IDLE;
                 else if (rx_valid_i && hcnt_q == 2'd3) state_d = S_CHECK;
      S_CHECK:   state_d = hdr_ok ? S_REPLAY : S_DISCARD;
      S_REPLAY:  if (rcnt_q == 2'd3) state_d = S_STREAM;
      S_STREAM:  if (abort) state_d = S_IDLE;
                 else if (take && pix_in_q + 32'd1 == total_q) state_d = S_DRAIN;
      S_DRAIN:   if (abort) state_d = S_IDLE;
                 else if (tx_hs && pix_out_q + 32'd1 == total_q) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      S_DISCARD: if (timeout_hit) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o        = (state_q != S_IDLE);
    frame_done_o  = (state_q == S_DONE);
    frame_error_o = ((state_q == S_CHECK) && !hdr_ok) || abort;
    core_rst_o    = rst_i || rst_q || (state_q == S_DONE) || abort ||
                    ((state_q == S_DISCARD) && timeout_hit);
    core_valid_o  = (state_q == S_REPLAY) || fwd_vld_q;
    core_data_o   = (state_q == S_REPLAY) ? hdr_q[rcnt_q] : fwd_q;
    core_ready_o  = out_room;
    tx_valid_o    = out_full_q;
    tx_data_o     = out_q;
  end

  always_comb begin
    hdr_d      = hdr_q;
    hcnt_d     = hcnt_q;
    rcnt_d     = rcnt_q;
    total_d    = total_q;
    pix_in_d   = pix_in_q;
    pix_out_d  = pix_out_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    fwd_d      = fwd_q;
    fwd_vld_d  = 1'b0;
    out_d      = out_q;
    out_full_d = out_full_q;
    idle_d     = (activity || state_d != state_q || state_q == S_IDLE) ? '0 : idle_q + IW'(1);

    case (state_q)
      S_IDLE: begin
        pix_in_d   = '0;
        pix_out_d  = '0;
        rcnt_d     = '0;
        skid_vld_d = 1'b0;
        if (rx_valid_i) begin
          hdr_d[0] = rx_data_i;
          hcnt_d   = 2'd1;
        end
      end
      S_HDR: if (rx_valid_i) begin
        hdr_d[hcnt_q] = rx_data_i;
        hcnt_d        = hcnt_q + 2'd1;
      end
      S_CHECK, S_REPLAY: begin
        if (state_q == S_CHECK) total_d = 32'(hdr_w) * 32'(hdr_h);
        else                    rcnt_d  = rcnt_q + 2'd1;
        if (rx_valid_i) begin
          skid_d     = rx_data_i;
          skid_vld_d = 1'b1;
        end
      end
      S_STREAM: if (take) begin
        // A byte held back during header replay goes out ahead of any new one.
        fwd_d      = skid_vld_q ? skid_q : rx_data_i;
        fwd_vld_d  = 1'b1;
        pix_in_d   = pix_in_q + 32'd1;
        skid_vld_d = skid_vld_q && rx_valid_i;
        if (skid_vld_q && rx_valid_i) skid_d = rx_data_i;
      end
      default: ;
    endcase

    if (tx_hs) begin
      out_full_d = 1'b0;
      pix_out_d  = pix_out_q + 32'd1;
    end
    if (core_out_valid_i && out_room) begin
      out_d      = core_out_data_i;
      out_full_d = 1'b1;
    end
    if (abort) out_full_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rst_q      <= 1'b1;
      hdr_q      <= '0;
      hcnt_q     <= '0;
      rcnt_q     <= '0;
      total_q    <= '0;
      pix_in_q   <= '0;
      pix_out_q  <= '0;
      idle_q     <= '0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      fwd_q      <= '0;
      fwd_vld_q  <= 1'b0;
      out_q      <= '0;
      out_full_q <= 1'b0;
    end else begin
      rst_q      <= 1'b0;
      hdr_q      <= hdr_d;
      hcnt_q     <= hcnt_d;
      rcnt_q     <= rcnt_d;
      total_q    <= total_d;
      pix_in_q   <= pix_in_d;
      pix_out_q  <= pix_out_d;
      idle_q     <= idle_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      fwd_q      <= fwd_d;
      fwd_vld_q  <= fwd_vld_d;
      out_q      <= out_d;
      out_full_q <= out_full_d;
    end
  end
endmodule
